mem_responder: RTL and testbench

Memory-side responder for the GPU external memory interface: the device that answers the per-channel valid/ready read and write requests the GPU issues. It holds a 2^ADDR_BITS-word array behind a single internal access port. Each channel runs its own request FSM with a programmable service delay, and a round-robin arbiter shares the array port among channels. It serves as the program-memory or data-memory model in system benches and as the on-FPGA memory, and has a backdoor load port for preloading kernels and data.

---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: per-channel valid/ready request FSMs with a programmable
// service delay, sharing one array port through a round-robin arbiter plus a backdoor load port.
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready,
    input  logic                                   load_valid,
    input  logic [ADDR_BITS-1:0]                   load_address,
    input  logic [DATA_BITS-1:0]                   load_data
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

    state_t                               state     [NUM_CHANNELS];
    state_t                               state_nxt [NUM_CHANNELS];
    logic [3:0]                           cnt       [NUM_CHANNELS];
    logic [3:0]                           cnt_nxt   [NUM_CHANNELS];
    logic                                 req_wr_p0     [NUM_CHANNELS];
    logic                                 req_wr_nxt    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]                 req_addr_p0   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]                 req_addr_nxt  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                 req_wdata_p0  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]                 req_wdata_nxt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rdata_p1;
    logic [DATA_BITS-1:0]                 mem [2**ADDR_BITS];

    logic [NUM_CHANNELS-1:0] wr_req;
    logic [NUM_CHANNELS-1:0] svc_valid;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_vld;
    logic [CH_W:0]           cand;

    always_comb begin
        wr_req    = '0;
        svc_valid = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            wr_req[i]    = (WRITE_ENABLE != 0) && mem_write_valid[i];
            // DRAIN/RESP watch only the valid of the op actually being serviced
            svc_valid[i] = req_wr_p0[i] ? wr_req[i] : mem_read_valid[i];
            eligible[i]  = (state[i] == WAIT) && (cnt[i] == 4'd0);
        end
    end

    // Round-robin search upward from rr_ptr+1; the load port blocks any grant
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        cand      = '0;
        if (!load_valid) begin
            for (int k = 1; k <= NUM_CHANNELS; k++) begin
                cand = {1'b0, rr_ptr} + (CH_W+1)'(k);
                if (cand >= (CH_W+1)'(NUM_CHANNELS))
                    cand = cand - (CH_W+1)'(NUM_CHANNELS);
                if (!grant_vld && eligible[cand[CH_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            state_nxt[i]     = state[i];
            cnt_nxt[i]       = cnt[i];
            req_wr_nxt[i]    = req_wr_p0[i];
            req_addr_nxt[i]  = req_addr_p0[i];
            req_wdata_nxt[i] = req_wdata_p0[i];
            case (state[i])
                IDLE: begin
                    if (wr_req[i]) begin
                        req_wr_nxt[i]    = 1'b1;
                        req_addr_nxt[i]  = mem_write_address[i];
                        req_wdata_nxt[i] = mem_write_data[i];
                        cnt_nxt[i]       = 4'(LATENCY);
                        state_nxt[i]     = WAIT;
                    end else if (mem_read_valid[i]) begin
                        req_wr_nxt[i]    = 1'b0;
                        req_addr_nxt[i]  = mem_read_address[i];
                        cnt_nxt[i]       = 4'(LATENCY);
                        state_nxt[i]     = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt[i] != 4'd0)
                        cnt_nxt[i] = cnt[i] - 4'd1;
                    else if (grant_vld && (grant_idx == CH_W'(i)))
                        state_nxt[i] = RESP;
                end
                RESP:  state_nxt[i] = svc_valid[i] ? DRAIN : IDLE;
                DRAIN: if (!svc_valid[i]) state_nxt[i] = IDLE;
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    // Control state: asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= 4'd0;
            end
            rr_ptr   <= CH_W'(NUM_CHANNELS - 1);
            rdata_p1 <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            if (grant_vld) begin
                rr_ptr <= grant_idx;
                if (!req_wr_p0[grant_idx])
                    rdata_p1[grant_idx] <= mem[req_addr_p0[grant_idx]];
            end
        end
    end

    // Request capture stage: data only, no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            req_wr_p0[i]    <= req_wr_nxt[i];
            req_addr_p0[i]  <= req_addr_nxt[i];
            req_wdata_p0[i] <= req_wdata_nxt[i];
        end
    end

    // Array port: contents survive reset
    always_ff @(posedge clk) begin
        if (load_valid)
            mem[load_address] <= load_data;
        else if (grant_vld && req_wr_p0[grant_idx])
            mem[req_addr_p0[grant_idx]] <= req_wdata_p0[grant_idx];
    end

    always_comb begin
        mem_read_ready  = '0;
        mem_write_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            mem_read_ready[i]  = (state[i] == RESP) && !req_wr_p0[i];
            mem_write_ready[i] = (WRITE_ENABLE != 0) && (state[i] == RESP) && req_wr_p0[i];
        end
    end

    assign mem_read_data = rdata_p1;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY 2 and 0) share stimulus and are
// compared each cycle against a transaction-level schedule and shadow-memory model.
module tb_mem_responder;

    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [NC-1:0]          rv, wv;
    logic [NC-1:0][AB-1:0]  ra, wa;
    logic [NC-1:0][DB-1:0]  wd;
    logic                   lv;
    logic [AB-1:0]          la;
    logic [DB-1:0]          ld;

    logic [NC-1:0]          rr_l2, wr_l2, rr_l0, wr_l0;
    logic [NC-1:0][DB-1:0]  rd_l2, rd_l0;

    mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(2), .WRITE_ENABLE(1)) dut_l2 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr_l2), .mem_read_data(rd_l2),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr_l2),
        .load_valid(lv), .load_address(la), .load_data(ld)
    );

    mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(0), .WRITE_ENABLE(1)) dut_l0 (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr_l0), .mem_read_data(rd_l0),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr_l0),
        .load_valid(lv), .load_address(la), .load_data(ld)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = LATENCY 2 instance, 1 = LATENCY 0 instance
    logic [DB-1:0] mem_m [2][256];
    int            ptr_m [2];

    // Round description
    logic [NC-1:0] rq_rd, rq_wr;
    logic [AB-1:0] rqa [NC];
    logic [DB-1:0] rqd [NC];
    int            ls, ll;
    logic [AB-1:0] lda [4];
    logic [DB-1:0] ldd [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [NC-1:0] rrdy(input int d);
        return (d == 0) ? rr_l2 : rr_l0;
    endfunction

    function automatic logic [NC-1:0] wrdy(input int d);
        return (d == 0) ? wr_l2 : wr_l0;
    endfunction

    function automatic logic [DB-1:0] rdat(input int d, input int c);
        return (d == 0) ? rd_l2[c] : rd_l0[c];
    endfunction

    task automatic clear_req();
        rq_rd = '0;
        rq_wr = '0;
        ls    = 100;
        ll    = 0;
        for (int c = 0; c < NC; c++) begin
            rqa[c] = '0;
            rqd[c] = '0;
        end
    endtask

    task automatic load_word(input logic [AB-1:0] a, input logic [DB-1:0] v);
        lv = 1'b1; la = a; ld = v;
        @(posedge clk);
        @(negedge clk);
        lv = 1'b0;
        mem_m[0][a] = v;
        mem_m[1][a] = v;
    endtask

    // All requests are raised together at edge 0 and held past every grant.
    // Grants go in round-robin order from the last granted channel, one per edge,
    // starting LATENCY+1 edges later and skipping edges where a load is active.
    task automatic run_round(input string tag);
        int            g  [2][NC];
        logic [DB-1:0] er [2][NC];
        int            e, c, last_g, hold, window, new_ptr;
        logic [NC-1:0] exp_r, exp_w;
        last_g = 0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NC; k++) begin
                g[d][k]  = -1;
                er[d][k] = '0;
            end
            e       = lat(d) + 1;
            new_ptr = ptr_m[d];
            for (int k = 1; k <= NC; k++) begin
                c = (ptr_m[d] + k) % NC;
                if (rq_rd[c] || rq_wr[c]) begin
                    while (e >= ls && e < ls + ll) e++;
                    g[d][c] = e;
                    new_ptr = c;
                    if (e > last_g) last_g = e;
                    e++;
                end
            end
            ptr_m[d] = new_ptr;
        end
        hold   = last_g + 2 + int'($urandom_range(0, 2));
        window = ((hold > ls + ll) ? hold : ls + ll) + 4;
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t <= window; t++) begin
                if (t >= ls && t < ls + ll) mem_m[d][lda[t-ls]] = ldd[t-ls];
                for (int k = 0; k < NC; k++) begin
                    if (g[d][k] == t) begin
                        if (rq_wr[k]) mem_m[d][rqa[k]] = rqd[k];
                        else          er[d][k] = mem_m[d][rqa[k]];
                    end
                end
            end
        end
        for (int k = 0; k < NC; k++) begin
            rv[k] = rq_rd[k]; ra[k] = rqa[k];
            wv[k] = rq_wr[k]; wa[k] = rqa[k]; wd[k] = rqd[k];
        end
        for (e = 0; e < window; e++) begin
            lv = (e >= ls && e < ls + ll);
            if (lv) begin
                la = lda[e-ls];
                ld = ldd[e-ls];
            end
            if (e >= hold) begin
                rv = '0;
                wv = '0;
            end else if (e >= 1) begin
                for (int k = 0; k < NC; k++) begin
                    ra[k] = AB'($urandom); wa[k] = AB'($urandom); wd[k] = DB'($urandom);
                end
            end
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NC; k++) begin
                    exp_r[k] = (g[d][k] == e) && rq_rd[k];
                    exp_w[k] = (g[d][k] == e) && rq_wr[k];
                end
                check_eq($sformatf("%s.rd_ready.d%0d.e%0d", tag, d, e), 32'(rrdy(d)), 32'(exp_r));
                check_eq($sformatf("%s.wr_ready.d%0d.e%0d", tag, d, e), 32'(wrdy(d)), 32'(exp_w));
                for (int k = 0; k < NC; k++)
                    if (exp_r[k])
                        check_eq($sformatf("%s.rd_data.d%0d.ch%0d", tag, d, k), 32'(rdat(d, k)), 32'(er[d][k]));
            end
        end
        lv = 1'b0;
        rv = '0;
        wv = '0;
    endtask

    // Write and read raised together on ch0: write first, read after write_valid drops
    task automatic rw_same_channel();
        int gw, gr;
        logic [NC-1:0] exp_r, exp_w;
        rv[0] = 1'b1; ra[0] = 8'h05;
        wv[0] = 1'b1; wa[0] = 8'h05; wd[0] = 8'h77;
        for (int e = 0; e < 20; e++) begin
            if (e >= 8)  wv[0] = 1'b0;
            if (e >= 16) rv[0] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                gw = lat(d) + 1;
                gr = 10 + lat(d);
                exp_w = (e == gw) ? NC'(1) : '0;
                exp_r = (e == gr) ? NC'(1) : '0;
                check_eq($sformatf("rw.wr_ready.d%0d.e%0d", d, e), 32'(wrdy(d)), 32'(exp_w));
                check_eq($sformatf("rw.rd_ready.d%0d.e%0d", d, e), 32'(rrdy(d)), 32'(exp_r));
                if (e == gr) check_eq($sformatf("rw.rd_data.d%0d", d), 32'(rdat(d, 0)), 32'h77);
            end
        end
        for (int d = 0; d < 2; d++) begin
            mem_m[d][8'h05] = 8'h77;
            ptr_m[d] = 0;
        end
    endtask

    initial begin
        reset = 1'b0;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        lv = 1'b0; la = '0; ld = '0;
        ptr_m[0] = NC - 1;
        ptr_m[1] = NC - 1;
        clear_req();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("reset.rd_ready.d%0d", d), 32'(rrdy(d)), 32'h0);
            check_eq($sformatf("reset.wr_ready.d%0d", d), 32'(wrdy(d)), 32'h0);
        end
        check_eq("reset.rd_data.d0", rd_l2, 32'h0);
        check_eq("reset.rd_data.d1", rd_l0, 32'h0);
        reset = 1'b1;

        for (int a = 0; a < 256; a++) load_word(AB'(a), DB'($urandom));
        load_word(8'h10, 8'hA5);

        clear_req(); rq_rd[0] = 1'b1; rqa[0] = 8'h10;
        run_round("single_read");

        clear_req(); rq_wr[1] = 1'b1; rqa[1] = 8'h20; rqd[1] = 8'h3C;
        run_round("write");
        clear_req(); rq_rd[1] = 1'b1; rqa[1] = 8'h20;
        run_round("read_back");
        clear_req(); rq_rd[2] = 1'b1; rqa[2] = 8'h21;
        run_round("neighbour");

        clear_req(); rq_rd[3] = 1'b1; rqa[3] = 8'h1F;
        run_round("ptr_to_3");
        for (int r = 0; r < 2; r++) begin
            clear_req();
            for (int c = 0; c < NC; c++) begin
                rq_rd[c] = 1'b1;
                rqa[c]   = AB'(8'h40 + c);
            end
            run_round($sformatf("contention%0d", r));
        end

        clear_req(); rq_rd[2] = 1'b1; rqa[2] = 8'h50;
        ls = 3; ll = 3;
        lda[0] = 8'h60; ldd[0] = 8'h9A;
        lda[1] = 8'h61; ldd[1] = 8'h9B;
        lda[2] = 8'h50; ldd[2] = 8'h9C;
        run_round("load_prio");
        clear_req(); rq_rd[0] = 1'b1; rqa[0] = 8'h60; rq_rd[1] = 1'b1; rqa[1] = 8'h61;
        run_round("load_verify");

        rw_same_channel();

        load_word(8'h30, 8'h11);
        wv[3] = 1'b1; wa[3] = 8'h30; wd[3] = 8'hEE;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_mid.wr_ready.d%0d", d), 32'(wrdy(d)), 32'h0);
            check_eq($sformatf("rst_mid.rd_ready.d%0d", d), 32'(rrdy(d)), 32'h0);
        end
        check_eq("rst_mid.rd_data.d0", rd_l2, 32'h0);
        check_eq("rst_mid.rd_data.d1", rd_l0, 32'h0);
        @(negedge clk);
        wv = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        ptr_m[0] = NC - 1;
        ptr_m[1] = NC - 1;
        clear_req(); rq_rd[3] = 1'b1; rqa[3] = 8'h30; rq_rd[0] = 1'b1; rqa[0] = 8'h10;
        run_round("after_reset");

        for (int r = 0; r < 40; r++) begin
            clear_req();
            for (int c = 0; c < NC; c++) begin
                int op;
                op = int'($urandom_range(0, 3));
                rq_rd[c] = (op == 1) || (op == 3);
                rq_wr[c] = (op == 2);
                rqa[c]   = ($urandom_range(0, 1) == 0) ? AB'($urandom_range(0, 7)) : AB'($urandom);
                rqd[c]   = DB'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                ls = int'($urandom_range(1, 5));
                ll = int'($urandom_range(1, 3));
                for (int k = 0; k < 4; k++) begin
                    lda[k] = AB'($urandom_range(0, 7));
                    ldd[k] = DB'($urandom);
                end
            end
            run_round($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
